// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle execution unit: decodes M-extension R-type instructions,
// runs a shift-add multiply or restoring divide over N cycles, and stalls the pipe while busy.
module muldiv_sequencer #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] Instruction,
  input  logic         valid,
  input  logic         kill,
  input  logic [N-1:0] rs1_data,
  input  logic [N-1:0] rs2_data,
  output logic         is_muldiv,
  output logic         stall,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  logic [1:0]     state_q, state_d;
  logic [2:0]     f3_q, f3_d;
  logic           sa_q, sa_d, sb_q, sb_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [2*N-1:0] mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   result_q, result_d;

  logic [2:0]     f3_in;
  logic           start, a_signed, b_signed, sa_in, sb_in;
  logic [N-1:0]   a_abs, b_abs, fast_res;
  logic           div_zero, div_ovf;
  logic [2*N-1:0] mul_sum, div_next, acc_step, prod;
  logic [N:0]     rem_sh, trial;
  logic [N-1:0]   quo, rem, res_fin;
  logic           unused_instr_bits;

  assign unused_instr_bits = ^{Instruction[24:15], Instruction[11:7]};

  assign f3_in     = Instruction[14:12];
  assign is_muldiv = (Instruction[6:0] == 7'b0110011) && (Instruction[31:25] == 7'b0000001);
  assign start     = valid && is_muldiv && (state_q == ST_IDLE) && !kill;
  assign stall     = start || (state_q == ST_CALC);
  assign done      = (state_q == ST_DONE);
  assign result    = result_q;

  // Operand signedness and magnitudes for the unsigned core
  always_comb begin
    a_signed = (f3_in == F3_MULH) || (f3_in == F3_MULHSU) || (f3_in == F3_DIV) || (f3_in == F3_REM);
    b_signed = (f3_in == F3_MULH) || (f3_in == F3_DIV) || (f3_in == F3_REM);
    sa_in    = a_signed && rs1_data[N-1];
    sb_in    = b_signed && rs2_data[N-1];
    a_abs    = sa_in ? -rs1_data : rs1_data;
    b_abs    = sb_in ? -rs2_data : rs2_data;
    div_zero = (rs2_data == '0);
    div_ovf  = ((f3_in == F3_DIV) || (f3_in == F3_REM)) &&
               (rs1_data == {1'b1, {(N-1){1'b0}}}) && (rs2_data == '1);
    if (div_zero)
      fast_res = f3_in[1] ? rs1_data : '1;
    else
      fast_res = f3_in[1] ? '0 : {1'b1, {(N-1){1'b0}}};
  end

  // One iteration: mul adds the shifted multiplicand; div does a restoring subtract on {rem,quo}
  always_comb begin
    mul_sum  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    rem_sh   = {acc_q[2*N-1:N], acc_q[N-1]};
    trial    = rem_sh - {1'b0, mplier_q};
    div_next = trial[N] ? {rem_sh[N-1:0], acc_q[N-2:0], 1'b0}
                        : {trial[N-1:0],  acc_q[N-2:0], 1'b1};
    acc_step = f3_q[2] ? div_next : mul_sum;
    prod     = (sa_q ^ sb_q) ? -acc_step : acc_step;
    quo      = acc_step[N-1:0];
    rem      = acc_step[2*N-1:N];
    case (f3_q)
      F3_MUL:                       res_fin = prod[N-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: res_fin = prod[2*N-1:N];
      F3_DIV, F3_DIVU:              res_fin = (sa_q ^ sb_q) ? -quo : quo;
      default:                      res_fin = sa_q ? -rem : rem;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          f3_d = f3_in;
          sa_d = sa_in;
          sb_d = sb_in;
          if (f3_in[2] && (div_zero || div_ovf)) begin
            result_d = fast_res;
            state_d  = ST_DONE;
          end else begin
            acc_d    = f3_in[2] ? {{N{1'b0}}, a_abs} : '0;
            mcand_d  = {{N{1'b0}}, a_abs};
            mplier_d = b_abs;
            cnt_d    = '0;
            state_d  = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (kill) begin
          state_d = ST_IDLE;
        end else begin
          acc_d    = acc_step;
          mcand_d  = mcand_q << 1;
          mplier_d = f3_q[2] ? mplier_q : (mplier_q >> 1);
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == CW'(N-1)) begin
            result_d = res_fin;
            state_d  = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      f3_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle RV32M execution unit and controller. Sits beside the integer ALU in the execute stage.
- Decodes M-extension R-type instructions, runs an iterative shift-add multiplier or restoring divider over N cycles, and stalls the pipeline while busy.
- Presents a one-cycle-valid result to the writeback mux.

Parameters:
- N, 32, operand/result width; iteration count per operation.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- Instruction  input  N  instruction in execute stage.
- valid  input  1  Instruction/operands are live this cycle.
- kill  input  1  pipeline flush; aborts any operation in progress.
- rs1_data  input  N  operand A (dividend / multiplicand).
- rs2_data  input  N  operand B (divisor / multiplier).
- is_muldiv  output  1  combinational decode of Instruction.
- stall  output  1  hold upstream stages this cycle.
- done  output  1  result valid this cycle (one-cycle pulse).
- result  output  N  operation result; held until next start.

Behaviour:
- Decode:
  - is_muldiv = opcode (bits 6:0) == 0110011 and funct7 (bits 31:25) == 0000001.
  - funct3 selects: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- start = valid & is_muldiv & (state==IDLE) & ~kill.
- Reset (rst=1 at posedge): state=IDLE, done=0, result=0, internal accumulators/counter=0. Reset mid-operation abandons it; no done pulse follows.
- States:
  - IDLE:
    - On start, latch funct3, compute sign flags, latch |A| and |B| per signedness (MULH/DIV/REM: both signed; MULHSU: A signed, B unsigned; others unsigned).
    - Fast path: divide with B==0, or signed divide with A==0x80000000 and B==0xFFFFFFFF, goes directly to DONE.
    - Otherwise clear the 2N-bit accumulator, set counter=0, and go to CALC.
  - CALC:
    - One iteration per cycle: multiply is a shift-add on one multiplier bit; divide is one restoring shift/subtract step.
    - Counter increments each cycle; after the N-th iteration (counter==N-1) go to DONE.
    - kill goes to IDLE; no done pulse, result unchanged.
  - DONE:
    - done=1 for exactly this cycle; result registered on entry.
    - Always returns to IDLE next cycle. start is ignored in DONE because the state is not IDLE.
- stall = start | (state==CALC). stall is 0 in IDLE without start and 0 in DONE, so the pipeline advances on the done cycle.
- Latency:
  - Normal path: accept at edge t, CALC for N cycles, done high in cycle t+N+1 (N+1 cycles after accept).
  - Fast path: done in cycle t+1.
- Result rules (all arithmetic modulo 2^N):
  - MUL: low N bits of the signed product.
  - MULH/MULHSU/MULHU: high N bits of the 2N-bit product. Negate the 2N-bit product before the split if signs differ.
  - DIV/DIVU: quotient, truncated toward zero; quotient negated if signs differ.
  - REM/REMU: remainder; takes the sign of the dividend.
  - Divide by zero: quotient = all ones; remainder = A (unmodified).
  - Signed overflow (A=0x80000000, B=0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- Simultaneous events:
  - rst beats everything.
  - kill beats start in the same cycle: no start, stall=0.
  - valid with a non-M instruction: ignored, stall=0.
  - kill in DONE has no effect; the done pulse still occurs.

Test Plan:
- MUL A=7, B=0xFFFFFFFD -> stall high for cycles t..t+N; done at t+33 (N=32); result=0xFFFFFFEB.
- MULHU A=B=0xFFFFFFFF -> result=0xFFFFFFFE. MULH same operands -> result=0x00000000. MULHSU A=0xFFFFFFFF, B=2 -> result=0xFFFFFFFF.
- DIV A=0xFFFFFFF9 (-7), B=2 -> result=0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Fast path:
  - DIVU A=5, B=0 -> done at t+1, result=0xFFFFFFFF.
  - REM A=7, B=0 -> result=7.
  - DIV 0x80000000 / 0xFFFFFFFF -> result=0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF -> result=0.
- Abort and reset:
  - Start DIV, assert kill in 10th CALC cycle -> IDLE next cycle, no done, stall drops, prior result kept.
  - Repeat with rst instead -> result=0.
- Back-to-back MULs with valid held high -> second accepted in the cycle after DONE; first done pulse, second done pulse N+2 cycles later.
- ADD instruction (funct7=0) with valid=1 -> is_muldiv=0, stall=0, done never asserted.
